// File: rtl/packer_pkg.sv
// Shared widths, lane types and lane-insert helper for the plaintext word packer.
package packer_pkg;

  localparam int unsigned BEAT_W    = 32;
  localparam int unsigned BEATS     = 4;
  localparam int unsigned WORD_W    = BEAT_W * BEATS;
  localparam int unsigned LANE_W    = 2;
  localparam int unsigned LAST_LANE = BEATS - 1;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [WORD_W-1:0] word_t;

  // Return w with lane k replaced by beat b (lane 0 = LSBs).
  function automatic word_t place_beat(input word_t w, input lane_t k, input beat_t b);
    word_t r;
    r = w;
    r[k*BEAT_W +: BEAT_W] = b;
    return r;
  endfunction

endpackage

// File: rtl/plaintext_word_packer_if.sv
// Plaintext stream in, FIFO write port out. s_last exists only with PACKER_FLUSH_EN.
interface plaintext_word_packer_if;
  import packer_pkg::*;

  beat_t s_data;
  logic  s_valid;
  logic  s_ready;
`ifdef PACKER_FLUSH_EN
  logic  s_last;
`endif
  word_t fifo_data;
  logic  fifo_wr_en;
  logic  fifo_full;

`ifdef PACKER_FLUSH_EN
  modport master (output s_data, s_valid, s_last, fifo_full,
                  input  s_ready, fifo_data, fifo_wr_en);
  modport slave  (input  s_data, s_valid, s_last, fifo_full,
                  output s_ready, fifo_data, fifo_wr_en);
`else
  modport master (output s_data, s_valid, fifo_full,
                  input  s_ready, fifo_data, fifo_wr_en);
  modport slave  (input  s_data, s_valid, fifo_full,
                  output s_ready, fifo_data, fifo_wr_en);
`endif

endinterface

// File: rtl/packer_out_reg.sv
// Output holding register: keeps a completed word until the FIFO accepts it.
module packer_out_reg
  import packer_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  word_t load_data,
  input  logic  fifo_full,
  output logic  out_valid,
  output word_t fifo_data,
  output logic  fifo_wr_en
);

  // Write whenever a word is held and the FIFO has room.
  assign fifo_wr_en = out_valid && !fifo_full;

  // Load only happens with the register empty, so load and write never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      fifo_data <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      fifo_data <= load_data;
    end else if (fifo_wr_en) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/plaintext_word_packer.sv
// Packs four 32-bit plaintext beats into a 128-bit FIFO word.
// Optional early flush via s_last when PACKER_FLUSH_EN is defined.
module plaintext_word_packer
  import packer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  plaintext_word_packer_if.slave bus,
  output lane_t                  beat_cnt,
  output logic [CNT_W-1:0]       word_count
);

  word_t asm_buf;
  word_t merged_c;
  word_t load_data_c;
  logic  out_valid;
  logic  accept_c;
  logic  last_c;
  logic  complete_c;
  logic  load_c;
  logic  pend_load_c;

`ifdef PACKER_FLUSH_EN
  // A flushed word parked in asm_buf while the output register is still busy.
  logic flush_pend;

  assign last_c      = bus.s_last;
  assign pend_load_c = flush_pend && !out_valid;
  assign bus.s_ready = !((beat_cnt == lane_t'(LAST_LANE)) && out_valid) && !flush_pend;
`else
  assign last_c      = 1'b0;
  assign pend_load_c = 1'b0;
  assign bus.s_ready = !((beat_cnt == lane_t'(LAST_LANE)) && out_valid);
`endif

  assign accept_c    = bus.s_valid && bus.s_ready;
  assign merged_c    = place_beat(asm_buf, beat_cnt, bus.s_data);
  assign complete_c  = accept_c && ((beat_cnt == lane_t'(LAST_LANE)) || last_c);
  assign load_c      = (complete_c && !out_valid) || pend_load_c;
  assign load_data_c = pend_load_c ? asm_buf : merged_c;

  // Assembly buffer; cleared after each hand-off so unfilled lanes read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_buf  <= '0;
      beat_cnt <= '0;
    end else if (accept_c) begin
      if (complete_c) begin
        beat_cnt <= '0;
        asm_buf  <= out_valid ? merged_c : '0;
      end else begin
        beat_cnt <= beat_cnt + lane_t'(1);
        asm_buf  <= merged_c;
      end
    end else if (pend_load_c) begin
      asm_buf <= '0;
    end
  end

`ifdef PACKER_FLUSH_EN
  // Track a flushed word waiting for the output register to drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend <= 1'b0;
    end else if (complete_c && out_valid) begin
      flush_pend <= 1'b1;
    end else if (pend_load_c) begin
      flush_pend <= 1'b0;
    end
  end
`endif

  // Count words actually written into the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
    end else if (bus.fifo_wr_en) begin
      word_count <= word_count + CNT_W'(1);
    end
  end

  packer_out_reg u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_c),
    .load_data  (load_data_c),
    .fifo_full  (bus.fifo_full),
    .out_valid  (out_valid),
    .fifo_data  (bus.fifo_data),
    .fifo_wr_en (bus.fifo_wr_en)
  );

endmodule

// File: tb/tb_plaintext_word_packer.sv
// Self-checking bench for plaintext_word_packer (flush feature follows PACKER_FLUSH_EN).
module tb_plaintext_word_packer;
  import packer_pkg::*;

  localparam int unsigned TB_CNT_W = 2;
`ifdef PACKER_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  lane_t               beat_cnt;
  logic [TB_CNT_W-1:0] word_count;

  plaintext_word_packer_if bus ();

  plaintext_word_packer #(.CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .beat_cnt   (beat_cnt),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit in_last;

  // Reference model: beats of the word being assembled, words waiting behind
  // the output register, and the output register itself.
  logic [31:0]  part_q[$];
  logic [127:0] held_q[$];
  bit           m_ov;
  logic [127:0] m_out;
  int unsigned  m_wc;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !((part_q.size() == 3 && m_ov) || held_q.size() != 0);
  endfunction

  function automatic logic [127:0] pack_part();
    logic [127:0] w;
    w = '0;
    foreach (part_q[i]) w |= 128'(part_q[i]) << (32 * i);
    return w;
  endfunction

  task automatic model_reset();
    part_q.delete();
    held_q.delete();
    m_ov  = 1'b0;
    m_out = '0;
    m_wc  = 0;
  endtask

  // Advance the model across one rising edge using the inputs presented.
  task automatic model_edge();
    bit wr, rdy, ov0;
    logic [127:0] w;
    ov0 = m_ov;
    rdy = exp_ready();
    wr  = m_ov && !bus.fifo_full;
    if (wr) begin
      m_ov = 1'b0;
      m_wc++;
    end
    if (bus.s_valid && rdy) begin
      part_q.push_back(bus.s_data);
      if (part_q.size() == 4 || in_last) begin
        w = pack_part();
        part_q.delete();
        if (!ov0) begin
          m_out = w;
          m_ov  = 1'b1;
        end else begin
          held_q.push_back(w);
        end
      end
    end else if (held_q.size() != 0 && !ov0) begin
      m_out = held_q.pop_front();
      m_ov  = 1'b1;
    end
  endtask

  task automatic check_all();
    check("s_ready",    128'(bus.s_ready),    128'(exp_ready()));
    check("fifo_wr_en", 128'(bus.fifo_wr_en), 128'(m_ov && !bus.fifo_full));
    check("fifo_data",  bus.fifo_data,        m_out);
    check("beat_cnt",   128'(beat_cnt),       128'(part_q.size()));
    check("word_count", 128'(word_count),     128'(m_wc % 4));
  endtask

  task automatic set_in(input bit v, input logic [31:0] d, input bit l, input bit f);
    bus.s_valid   = v;
    bus.s_data    = d;
    bus.fifo_full = f;
    in_last       = l && FLUSH;
`ifdef PACKER_FLUSH_EN
    bus.s_last    = in_last;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit f);
    set_in(1'b0, '0, 1'b0, f);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present one beat until the model says it was taken (bounded).
  task automatic send(input logic [31:0] d, input bit l, input bit f);
    bit done;
    done = 1'b0;
    set_in(1'b1, d, l, f);
    for (int i = 0; i < 64 && !done; i++) begin
      done = exp_ready();
      step();
    end
    check("send_accept", 128'(done), 128'(1));
  endtask

  // Asynchronous reset asserted mid-cycle, held across one edge.
  task automatic do_reset();
    set_in(1'b0, '0, 1'b0, bus.fifo_full);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_wr_en",   128'(bus.fifo_wr_en), 128'(0));
    check("rst_data",    bus.fifo_data,        128'(0));
    check("rst_beat",    128'(beat_cnt),       128'(0));
    check("rst_count",   128'(word_count),     128'(0));
    check("rst_s_ready", 128'(bus.s_ready),    128'(1));
    @(posedge clk);
    #1;
    check("rst_hold_wr", 128'(bus.fifo_wr_en), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int seq[5];
    seq = '{1, 2, 3, 0, 1};
    rst_n = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single word
    do_reset();
    send(32'h11111111, 1'b0, 1'b0);
    send(32'h22222222, 1'b0, 1'b0);
    send(32'h33333333, 1'b0, 1'b0);
    send(32'h44444444, 1'b0, 1'b0);
    check("t1_wr_en", 128'(bus.fifo_wr_en), 128'(1));
    check("t1_data", bus.fifo_data, 128'h44444444_33333333_22222222_11111111);
    idle(1, 1'b0);
    check("t1_wr_once", 128'(bus.fifo_wr_en), 128'(0));
    check("t1_count", 128'(word_count), 128'(1));

    // Back-to-back
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(32'(i), 1'b0, 1'b0);
      check("t2_ready", 128'(bus.s_ready), 128'(1));
      if (i == 3) check("t2_word0", bus.fifo_data, {32'h3, 32'h2, 32'h1, 32'h0});
      if (i == 7) check("t2_word1", bus.fifo_data, {32'h7, 32'h6, 32'h5, 32'h4});
    end
    idle(1, 1'b0);
    check("t2_count", 128'(word_count), 128'(2));

    // Back-pressure
    do_reset();
    for (int i = 0; i < 4; i++) send({4{8'hA0 + 8'(i)}}, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send({4{8'hB0 + 8'(i)}}, 1'b0, 1'b1);
      check("t3_hold", bus.fifo_data, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
    end
    set_in(1'b1, {4{8'hB3}}, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_stall", 128'(bus.s_ready), 128'(0));
      check("t3_no_wr", 128'(bus.fifo_wr_en), 128'(0));
    end
    send({4{8'hB3}}, 1'b0, 1'b0);
    check("t3_wr_b", 128'(bus.fifo_wr_en), 128'(1));
    check("t3_data_b", bus.fifo_data, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
    idle(2, 1'b0);
    check("t3_count", 128'(word_count), 128'(2));

`ifdef PACKER_FLUSH_EN
    // Flush
    do_reset();
    send(32'hAAAAAAAA, 1'b0, 1'b0);
    send(32'hBBBBBBBB, 1'b1, 1'b0);
    check("t4_wr_en", 128'(bus.fifo_wr_en), 128'(1));
    check("t4_data", bus.fifo_data, 128'h00000000_00000000_BBBBBBBB_AAAAAAAA);
    check("t4_beat", 128'(beat_cnt), 128'(0));
    idle(1, 1'b0);
`endif

    // Reset mid-operation: partial word, then pending word under full
    do_reset();
    send(32'hDEAD0001, 1'b0, 1'b0);
    send(32'hDEAD0002, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) send(32'hC0DE0000 + 32'(i), 1'b0, 1'b1);
    idle(2, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) send(32'h5A000000 + 32'(i), 1'b0, 1'b0);
    check("t5_clean", bus.fifo_data, 128'h5A000003_5A000002_5A000001_5A000000);
    idle(1, 1'b0);

    // Counter wrap (2-bit counter)
    do_reset();
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < 4; i++) send($urandom, 1'b0, 1'b0);
      idle(1, 1'b0);
      check("t6_wrap", 128'(word_count), 128'(seq[w]));
    end

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      set_in($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 2,
             $urandom_range(0, 9) < 3);
      step();
      if (c == 1000) do_reset();
    end
    idle(10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/plaintext_word_packer.md
# plaintext_word_packer

Upstream feeder for the 128-bit encrypted FIFO top level. Accepts a 32-bit valid/ready plaintext stream, packs four beats into one 128-bit word, and writes completed words into the FIFO's plaintext write port via `wr_en`, honouring `full_o`. A single output holding register decouples assembly from FIFO back-pressure, so no accepted data is ever dropped.

## Interface
Parameters:
- `CNT_W`, default 16: width of the `word_count` status counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  32  plaintext beat.
- `s_valid`  in  1  beat valid.
- `s_ready`  out  1  beat accepted when `s_valid && s_ready` at the clock edge.
- `s_last`  in  1  flush marker. Present only with `PACKER_FLUSH_EN`.
- `fifo_data`  out  128  packed word; connects to `plain_data_in`.
- `fifo_wr_en`  out  1  write strobe; connects to `wr_en`.
- `fifo_full`  in  1  connects to `full_o`.
- `beat_cnt`  out  2  number of beats held in the assembly buffer.
- `word_count`  out  `CNT_W`  words written to the FIFO; wraps modulo 2^`CNT_W`.

## Operation
- **Assembly buffer:** 128-bit register plus a 2-bit `beat_cnt`.
  - Beat k (k = `beat_cnt`) is written to bits [32k+31:32k]. Beat 0 occupies the LSBs.
- **Output register:** `fifo_data` with flag `out_valid`.
- **Completing a word:** on the accepted beat with `beat_cnt==3`:
  - the full word (including the new beat) is loaded into `fifo_data`;
  - `out_valid` is set;
  - `beat_cnt` returns to 0.
- **Write strobe:** `fifo_wr_en = out_valid && !fifo_full`.
  - A cycle with `fifo_wr_en=1` clears `out_valid` at the next edge and increments `word_count`.
- **Ready:** `s_ready = !(beat_cnt==3 && out_valid)`.
  - Beats 0–2 of the next word are accepted while the output is pending.
  - The completing beat stalls until the output register is empty.
  - There is no combinational path from `fifo_full` to `s_ready`.
- **Full FIFO:** while `fifo_full=1`, `fifo_data` holds stable and `fifo_wr_en=0`.
- **Reset (async):**
  - `beat_cnt=0`, `out_valid=0`, `fifo_data=0`, `word_count=0`.
  - `fifo_wr_en=0`; `s_ready=1` once reset is released.
  - A partial word or a pending word present at reset is discarded, with no write.

## Timing
- **Latency:** completing beat accepted at edge N → `fifo_wr_en` high during cycle N+1, provided `fifo_full=0`.
- **Throughput:** 1 beat/cycle sustained with `fifo_full=0`; one word every 4 cycles, no bubbles.
- **Pending word:** `fifo_data` changes only at a load edge, and a load never overwrites a pending word.
- **Counter:** `word_count` updates at the edge that ends the write cycle.

## Configuration
- **`PACKER_FLUSH_EN` defined:**
  - `s_last` port exists.
  - An accepted beat with `s_last=1` completes the word immediately. Unfilled upper lanes are zero.
  - Flush obeys the same `s_ready` rule with the current `beat_cnt`: the flush beat stalls if `out_valid=1` and `beat_cnt==3`. With `beat_cnt<3` it is accepted; if `out_valid` is still 1 at that point, the flushed word is held in the assembly buffer and `s_ready` drops until the output register empties.
  - `s_last` with `beat_cnt==3` behaves as a normal completion.
- **`PACKER_FLUSH_EN` undefined:**
  - No `s_last` port.
  - Only full 4-beat words are ever written.

## Structure
- **Shared package `packer_pkg`:**
  - `BEAT_W=32`, `BEATS=4`, `WORD_W=128`.
  - Lane index type (2 bits).
- **Sub-module `packer_out_reg`:** the output holding register. It takes a load/data input, drives `out_valid`, `fifo_data` and `fifo_wr_en`, and receives `fifo_full`.
- Assembly logic and counters stay in the top module.

## Test plan
1. **Single word:** reset, then beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 with `fifo_full=0` → one cycle after the 4th beat, `fifo_wr_en=1` for one cycle, `fifo_data=0x44444444_33333333_22222222_11111111`, then `word_count=1`.
2. **Back-to-back:** 8 consecutive beats 0x0..0x7 with `fifo_full=0` → `s_ready` never low; words 0x3_2_1_0 and 0x7_6_5_4 written (each lane zero-extended to 32 bits); `word_count=2`.
3. **Back-pressure:** `fifo_full=1` from the completion of word A for 6 cycles, stream continues → `fifo_wr_en=0` and `fifo_data=A` stable; next 3 beats accepted; `s_ready=0` at `beat_cnt==3`; after `fifo_full` drops, A is written, then B one cycle after its completing beat; no beat lost.
4. **Flush (`PACKER_FLUSH_EN`):** beats 0xAAAAAAAA, then 0xBBBBBBBB with `s_last=1` → written word 0x00000000_00000000_BBBBBBBB_AAAAAAAA; `beat_cnt=0`.
5. **Reset mid-operation:** assert `rst_n=0` after 2 beats, and again with a pending word under `fifo_full=1` → no `fifo_wr_en` pulse; all outputs at reset values; the next 4 beats form a clean word.
6. **Counter wrap:** with `CNT_W=2`, write 5 words → `word_count` sequence 1, 2, 3, 0, 1.
